// File: rtl/wb_rom_copier.sv
// wb_rom_copier: Wishbone master copying WORDS words from ROM to RAM; checksum built only when ROM_COPIER_CHECKSUM_EN is defined
module wb_rom_copier #(
  parameter logic [31:0] SRC_BASE    = 32'h0000_0000,
  parameter logic [31:0] DST_BASE    = 32'h0000_0000,
  parameter int unsigned WORDS       = 32,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [31:0] checksum_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);
  typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP, DONE, ERR} state_t;
  localparam logic [15:0] LAST = 16'(WORDS - 1);
  localparam logic [15:0] TMO  = 16'(ACK_TIMEOUT);
  state_t      r_state, w_next;
  logic [15:0] r_idx, r_tmo, w_idx;
  logic [31:0] r_adr, r_dat;
  logic        r_cyc, r_we, r_busy, r_done, r_err;
  logic        w_bus, w_go, w_abort, w_rd_ack;
  always_comb begin
    w_bus    = r_state == RD || r_state == WR;
    w_go     = r_state == IDLE && start_i;
    w_abort  = w_bus && (wbm_err_i || (!wbm_ack_i && r_tmo == TMO));
    w_rd_ack = r_state == RD && wbm_ack_i && !wbm_err_i;
    w_idx    = w_go ? '0 : (r_state == WR_GAP && r_idx != LAST) ? r_idx + 16'd1 : r_idx;
    w_next   = w_abort ? ERR :
               w_go ? RD :
               r_state == RD ? (wbm_ack_i ? RD_GAP : RD) :
               r_state == RD_GAP ? WR :
               r_state == WR ? (wbm_ack_i ? WR_GAP : WR) :
               r_state == WR_GAP ? (r_idx == LAST ? DONE : RD) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_tmo   <= '0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx;
      r_tmo   <= (w_bus && w_next == r_state) ? r_tmo + 16'd1 : '0;
      r_cyc   <= w_next == RD || w_next == WR;
      r_we    <= w_next == WR;
      r_busy  <= w_next inside {RD, RD_GAP, WR, WR_GAP};
      r_done  <= w_next == DONE;
      r_err   <= !w_go && (r_err || w_next == ERR);
      if (w_rd_ack) r_dat <= wbm_dat_i;
      if (w_next == RD || w_next == WR) r_adr <= (w_next == RD ? SRC_BASE : DST_BASE) + {14'd0, w_idx, 2'b00};
    end
  end
`ifdef ROM_COPIER_CHECKSUM_EN
  logic [31:0] r_sum;
  always_ff @(posedge clk) begin
    if (rst || w_go) r_sum <= '0;
    else if (w_rd_ack) r_sum <= r_sum + wbm_dat_i;
  end
  assign checksum_o = r_sum;
`else
  assign checksum_o = '0;
`endif
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign error_o   = r_err;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = 4'hF;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
endmodule

// File: tb/tb_wb_rom_copier.sv
// tb_wb_rom_copier: randomized self-checking bench comparing bus transactions against a transaction-level copy model
module tb_wb_rom_copier;
  localparam int RD_LAT = 16;
  localparam logic [2:0][31:0] P_SRC = {32'h0000_0000, 32'h0000_0040, 32'h0000_0000};
  localparam logic [2:0][31:0] P_DST = {32'h0000_0200, 32'hFFFF_FFFC, 32'h0000_0100};
  localparam logic [2:0][15:0] P_NW  = {16'd4, 16'd1, 16'd4};
  localparam logic [2:0][15:0] P_TO  = {16'd8, 16'd255, 16'd255};
`ifdef ROM_COPIER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  typedef struct {logic we; logic [31:0] adr; logic [31:0] dat; int t0; int t1;} txn_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] start = '0;
  logic [2:0] busy, done, error, we, cyc, stb, ack, err;
  logic [31:0] adr [3];
  logic [31:0] dat_o [3];
  logic [31:0] dat_i [3];
  logic [31:0] csum [3];
  logic [3:0] sel [3];
  logic [4:0] wcnt [3];
  logic [31:0] rom [4];
  logic [31:0] err_at = '1;
  int cur_g = 0;
  int ncyc = 0;
  int ndone = 0;
  int t_done = 0;
  int t_fall = 0;
  int errs = 0;
  int nchk = 0;
  logic p_cyc = 1'b0;
  txn_t cur;
  txn_t log_q [$];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    wb_rom_copier #(
      .SRC_BASE(P_SRC[g]), .DST_BASE(P_DST[g]), .WORDS(32'(P_NW[g])), .ACK_TIMEOUT(32'(P_TO[g]))
    ) dut (
      .clk(clk), .rst(rst), .start_i(start[g]), .busy_o(busy[g]), .done_o(done[g]),
      .error_o(error[g]), .checksum_o(csum[g]), .wbm_adr_o(adr[g]), .wbm_dat_o(dat_o[g]),
      .wbm_dat_i(dat_i[g]), .wbm_we_o(we[g]), .wbm_sel_o(sel[g]), .wbm_cyc_o(cyc[g]),
      .wbm_stb_o(stb[g]), .wbm_ack_i(ack[g]), .wbm_err_i(err[g])
    );
  end
  always_ff @(posedge clk)
    for (int g = 0; g < 3; g++) wcnt[g] <= (cyc[g] && !we[g] && !ack[g]) ? wcnt[g] + 5'd1 : '0;
  always_comb begin
    ack = '0;
    err = '0;
    for (int g = 0; g < 3; g++) begin
      dat_i[g] = (cyc[g] && !we[g]) ? rom[2'((adr[g] - P_SRC[g]) >> 2)] : '0;
      ack[g] = cyc[g] && stb[g] && (we[g] || (g != 2 && wcnt[g] == 5'd16));
      err[g] = ack[g] && !we[g] && ((adr[g] - P_SRC[g]) >> 2) == err_at;
    end
  end
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    ncyc++;
    if (cyc[cur_g] && !p_cyc) begin
      cur.we = we[cur_g];
      cur.adr = adr[cur_g];
      cur.t0 = ncyc;
    end
    if (!cyc[cur_g] && p_cyc) t_fall = ncyc;
    if (ack[cur_g] && !err[cur_g]) begin
      cur.dat = we[cur_g] ? dat_o[cur_g] : dat_i[cur_g];
      cur.t1 = ncyc;
      log_q.push_back(cur);
    end
    if (done[cur_g]) begin
      ndone++;
      t_done = ncyc;
      check("busy_at_done", 32'(busy[cur_g]), 32'd0);
    end
    p_cyc = cyc[cur_g];
  endtask
  function automatic logic [31:0] sum_model(int n);
    logic [31:0] s = '0;
    for (int i = 0; i < n; i++) s += rom[i];
    return CSUM_EN ? s : '0;
  endfunction
  task automatic go(output int c0);
    log_q.delete();
    ndone = 0;
    start[cur_g] = 1'b1;
    c0 = ncyc;
    tick();
    start[cur_g] = 1'b0;
  endtask
  task automatic wait_end(int budget);
    int n = 0;
    while (ndone == 0 && !error[cur_g] && n < budget) begin
      tick();
      n++;
    end
    check("finished_in_budget", 32'(ndone != 0 || error[cur_g]), 32'd1);
  endtask
  task automatic verify(int n, int c0, int base, output int t);
    txn_t x;
    logic rd;
    int j;
    t = c0 + 1;
    for (int i = 0; i < 2 * n && base + i < log_q.size(); i++) begin
      x = log_q[base + i];
      j = i / 2;
      rd = (i % 2) == 0;
      check("we", 32'(x.we), 32'(!rd));
      check(rd ? "rd_adr" : "wr_adr", x.adr, (rd ? P_SRC[cur_g] : P_DST[cur_g]) + 32'(4 * j));
      check(rd ? "rd_dat" : "wr_dat", x.dat, rom[j]);
      check("t_start", x.t0, t);
      check("t_ack", x.t1, t + (rd ? RD_LAT : 0));
      t = t + (rd ? RD_LAT : 0) + 2;
    end
  endtask
  task automatic copy_and_check();
    int c0, t;
    int n = int'(P_NW[cur_g]);
    go(c0);
    wait_end(400);
    repeat (3) tick();
    check("n_txn", log_q.size(), 2 * n);
    check("n_done", ndone, 1);
    verify(n, c0, 0, t);
    check("t_done", t_done, t);
    check("error", 32'(error[cur_g]), 32'd0);
    check("checksum", csum[cur_g], sum_model(n));
  endtask
  initial begin
    int c0, t, t1st, nw;
    repeat (3) tick();
    for (int g = 0; g < 3; g++) begin
      check("rst_ctl", 32'({busy[g], done[g], error[g], cyc[g], stb[g], we[g]}), 32'd0);
      check("rst_adr", adr[g], 32'd0);
      check("rst_dat", dat_o[g], 32'd0);
      check("rst_csum", csum[g], 32'd0);
      check("rst_sel", 32'(sel[g]), 32'hF);
    end
    rst = 1'b0;
    tick();
    rom = '{32'd1, 32'd2, 32'd3, 32'd4};
    copy_and_check();
    repeat (3) begin
      foreach (rom[i]) rom[i] = $urandom();
      copy_and_check();
    end
    cur_g = 1;
    p_cyc = 1'b0;
    foreach (rom[i]) rom[i] = $urandom();
    copy_and_check();
    cur_g = 2;
    p_cyc = 1'b0;
    go(c0);
    wait_end(100);
    repeat (3) tick();
    check("to_cyc_high", t_fall - cur.t0, int'(P_TO[2]) + 1);
    check("to_error", 32'(error[2]), 32'd1);
    check("to_txn", log_q.size(), 0);
    check("to_done", ndone, 0);
    check("to_busy", 32'(busy[2]), 32'd0);
    check("to_csum", csum[2], 32'd0);
    cur_g = 0;
    p_cyc = 1'b0;
    foreach (rom[i]) rom[i] = $urandom();
    err_at = 32'd1;
    go(c0);
    wait_end(200);
    repeat (3) tick();
    check("ea_error", 32'(error[0]), 32'd1);
    check("ea_txn", log_q.size(), 2);
    nw = 0;
    foreach (log_q[i]) nw += int'(log_q[i].we);
    check("ea_writes", nw, 1);
    check("ea_done", ndone, 0);
    check("ea_csum", csum[0], sum_model(1));
    err_at = '1;
    go(c0);
    check("ea_clear", 32'(error[0]), 32'd0);
    wait_end(400);
    repeat (3) tick();
    check("ea_n_txn", log_q.size(), 8);
    verify(4, c0, 0, t);
    check("ea_t_done", t_done, t);
    foreach (rom[i]) rom[i] = $urandom();
    go(c0);
    nw = 0;
    while (!(log_q.size() == 6 && cyc[0] && we[0]) && nw < 200) begin
      tick();
      nw++;
    end
    check("mid_reached", 32'(nw < 200), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_cyc", 32'(cyc[0]), 32'd0);
    check("mid_busy", 32'(busy[0]), 32'd0);
    check("mid_ctl", 32'({done[0], error[0], stb[0], we[0]}), 32'd0);
    check("mid_adr", adr[0], 32'd0);
    check("mid_dat", dat_o[0], 32'd0);
    check("mid_csum", csum[0], 32'd0);
    rst = 1'b0;
    repeat (5) tick();
    check("mid_idle", 32'(cyc[0]), 32'd0);
    copy_and_check();
    foreach (rom[i]) rom[i] = $urandom();
    log_q.delete();
    ndone = 0;
    start[0] = 1'b1;
    c0 = ncyc;
    nw = 0;
    while (ndone < 1 && nw < 400) begin
      tick();
      nw++;
    end
    t1st = t_done;
    repeat (3) tick();
    start[0] = 1'b0;
    nw = 0;
    while (ndone < 2 && nw < 400) begin
      tick();
      nw++;
    end
    repeat (30) tick();
    check("hold_done", ndone, 2);
    check("hold_txn", log_q.size(), 16);
    verify(4, c0, 0, t);
    check("hold_t_done1", t1st, t);
    verify(4, t1st + 1, 8, t);
    check("hold_t_done2", t_done, t);
    check("hold_csum", csum[0], sum_model(4));
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
